// File: rtl/seg_pkg.sv
// Shared constants for the 6-digit 7-segment display path: segment patterns,
// digit select codes and the select decoder used by the capture block.
package seg_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int NUM_W      = 24;

   // Active-low segment patterns, bit7..bit1 = a..g, bit0 = dp (off)
   localparam logic [7:0] SEG_0 = 8'h03;
   localparam logic [7:0] SEG_1 = 8'h9F;
   localparam logic [7:0] SEG_2 = 8'h25;
   localparam logic [7:0] SEG_3 = 8'h0D;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h49;
   localparam logic [7:0] SEG_6 = 8'h41;
   localparam logic [7:0] SEG_7 = 8'h1F;
   localparam logic [7:0] SEG_8 = 8'h01;
   localparam logic [7:0] SEG_9 = 8'h09;
   localparam logic [7:0] SEG_A = 8'h05;
   localparam logic [7:0] SEG_B = 8'hC1;
   localparam logic [7:0] SEG_C = 8'h63;
   localparam logic [7:0] SEG_D = 8'h85;
   localparam logic [7:0] SEG_E = 8'h61;
   localparam logic [7:0] SEG_F = 8'h71;

   localparam logic [5:0] SEL_D0    = 6'b011111;
   localparam logic [5:0] SEL_D1    = 6'b101111;
   localparam logic [5:0] SEL_D2    = 6'b110111;
   localparam logic [5:0] SEL_D3    = 6'b111011;
   localparam logic [5:0] SEL_D4    = 6'b111101;
   localparam logic [5:0] SEL_D5    = 6'b111110;
   localparam logic [5:0] SEL_BLANK = 6'b111111;

   typedef enum logic [1:0] {SEL_NONE, SEL_ONE, SEL_MULTI} sel_kind_e;

   typedef struct packed {
      sel_kind_e  kind;
      logic [2:0] idx;
   } sel_dec_t;

   typedef enum logic {ST_IDLE, ST_COLLECT} cap_state_e;

   function automatic sel_dec_t sel_decode(input logic [5:0] ncs);
      sel_dec_t d;
      d.kind = SEL_MULTI;
      d.idx  = 3'd0;
      case (ncs)
         SEL_D0:    begin d.kind = SEL_ONE; d.idx = 3'd0; end
         SEL_D1:    begin d.kind = SEL_ONE; d.idx = 3'd1; end
         SEL_D2:    begin d.kind = SEL_ONE; d.idx = 3'd2; end
         SEL_D3:    begin d.kind = SEL_ONE; d.idx = 3'd3; end
         SEL_D4:    begin d.kind = SEL_ONE; d.idx = 3'd4; end
         SEL_D5:    begin d.kind = SEL_ONE; d.idx = 3'd5; end
         SEL_BLANK: d.kind = SEL_NONE;
         default:   d.kind = SEL_MULTI;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/seg8_rev_lut.sv
// Reverse segment lookup: a..g pattern back to a hex nibble, flagging
// patterns that no hex digit produces.
module seg8_rev_lut
   import seg_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic       o_valid,
   output logic [3:0] o_nibble
);

   always_comb begin
      o_valid  = 1'b1;
      o_nibble = 4'h0;
      case (i_seg)
         SEG_0[7:1]: o_nibble = 4'h0;
         SEG_1[7:1]: o_nibble = 4'h1;
         SEG_2[7:1]: o_nibble = 4'h2;
         SEG_3[7:1]: o_nibble = 4'h3;
         SEG_4[7:1]: o_nibble = 4'h4;
         SEG_5[7:1]: o_nibble = 4'h5;
         SEG_6[7:1]: o_nibble = 4'h6;
         SEG_7[7:1]: o_nibble = 4'h7;
         SEG_8[7:1]: o_nibble = 4'h8;
         SEG_9[7:1]: o_nibble = 4'h9;
         SEG_A[7:1]: o_nibble = 4'hA;
         SEG_B[7:1]: o_nibble = 4'hB;
         SEG_C[7:1]: o_nibble = 4'hC;
         SEG_D[7:1]: o_nibble = 4'hD;
         SEG_E[7:1]: o_nibble = 4'hE;
         SEG_F[7:1]: o_nibble = 4'hF;
         default:    o_valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a scanned 6-digit 7-segment display back into a 24-bit value,
// with per-digit stability filtering, frame assembly and timeout.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int STABLE_CYC  = 1,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg_leds,
   input  logic [5:0]  seg_ncs,
   output logic [23:0] num,
   output logic        num_valid,
   output logic        frame_err,
   output logic [5:0]  digit_mask
);

   localparam logic [3:0]  STAB_TGT = 4'(STABLE_CYC);
   localparam logic [15:0] TMO_TGT  = 16'(TIMEOUT_CYC);

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   logic [7:0]            r_leds_p0, r_leds_p1;
   logic [5:0]            r_ncs_p0, r_ncs_p1;
   logic [3:0]            r_stab;
   cap_state_e            r_state;
   logic [NUM_DIGITS-1:0] r_mask;
   logic [NUM_W-1:0]      r_shadow;
   logic [NUM_W-1:0]      r_num;
   logic                  r_valid;
   logic                  r_err;
   logic [15:0]           r_tmo;

   sel_dec_t              w_dec;
   logic                  w_same;
   logic [3:0]            w_stab_nxt;
   logic                  w_act;
   logic                  w_lut_vld;
   logic [3:0]            w_lut_nib;
   logic                  w_accept;
   logic                  w_bad;
   logic [NUM_DIGITS-1:0] w_bit;
   logic [NUM_DIGITS-1:0] w_mask_set;
   logic                  w_commit;
   logic                  w_tmo_hit;
   logic [NUM_W-1:0]      w_shadow_nxt;

   seg8_rev_lut u_lut (
      .i_seg    (r_leds_p0[7:1]),
      .o_valid  (w_lut_vld),
      .o_nibble (w_lut_nib)
   );

   // p0: registered bus sample, p1: previous sample for the stability compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_leds_p0 <= 8'hFF;
         r_ncs_p0  <= SEL_BLANK;
         r_leds_p1 <= 8'hFF;
         r_ncs_p1  <= SEL_BLANK;
         r_stab    <= 4'd0;
      end else begin
         r_leds_p0 <= seg_leds;
         r_ncs_p0  <= seg_ncs;
         r_leds_p1 <= r_leds_p0;
         r_ncs_p1  <= r_ncs_p0;
         r_stab    <= w_stab_nxt;
      end
   end

   assign w_dec  = sel_decode(r_ncs_p0);
   assign w_same = ({r_ncs_p0, r_leds_p0} == {r_ncs_p1, r_leds_p1});

   always_comb begin
      w_stab_nxt = 4'd0;
      if (w_dec.kind == SEL_NONE)
         w_stab_nxt = 4'd0;
      else if (!w_same)
         w_stab_nxt = 4'd1;
      else
         w_stab_nxt = sat_inc4(r_stab);
   end

   // A run fires once: on reaching the target, never again while saturated
   assign w_act      = (w_dec.kind != SEL_NONE) && (w_stab_nxt == STAB_TGT) &&
                       (!w_same || (r_stab != STAB_TGT));
   assign w_accept   = w_act && (w_dec.kind == SEL_ONE) && w_lut_vld;
   assign w_bad      = w_act && !w_accept;
   assign w_bit      = NUM_DIGITS'(1) << w_dec.idx;
   assign w_mask_set = r_mask | w_bit;
   assign w_commit   = w_accept && (&w_mask_set);
   assign w_tmo_hit  = ((r_tmo + 16'd1) == TMO_TGT);

   always_comb begin
      w_shadow_nxt = r_shadow;
      w_shadow_nxt[{w_dec.idx, 2'b00} +: 4] = w_lut_nib;
   end

   // Frame assembly FSM, all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_mask   <= '0;
         r_shadow <= '0;
         r_num    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_tmo    <= 16'd0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tmo <= 16'd0;
               if (w_bad) begin
                  r_err <= 1'b1;
               end else if (w_accept) begin
                  r_shadow <= w_shadow_nxt;
                  r_mask   <= w_bit;
                  r_state  <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (w_bad) begin
                  r_err   <= 1'b1;
                  r_mask  <= '0;
                  r_tmo   <= 16'd0;
                  r_state <= ST_IDLE;
               end else if (w_accept) begin
                  r_shadow <= w_shadow_nxt;
                  r_tmo    <= 16'd0;
                  if (w_commit) begin
                     r_num   <= w_shadow_nxt;
                     r_valid <= 1'b1;
                     r_mask  <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_mask <= w_mask_set;
                  end
               end else if (w_tmo_hit) begin
                  r_err   <= 1'b1;
                  r_mask  <= '0;
                  r_tmo   <= 16'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign num        = r_num;
   assign num_valid  = r_valid;
   assign frame_err  = r_err;
   assign digit_mask = r_mask;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: frame table plus hand-written corner sequences,
// with committed values checked through a scoreboard queue.
module tb_seg_scan_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  leds_a = 8'hFF, leds_b = 8'hFF;
   logic [5:0]  ncs_a = 6'h3F, ncs_b = 6'h3F;
   logic [23:0] num_a, num_b;
   logic        vld_a, vld_b, err_a, err_b;
   logic [5:0]  mask_a, mask_b;

   seg_scan_capture #(.STABLE_CYC(1), .TIMEOUT_CYC(64)) u_a (
      .clk(clk), .rst_n(rst_n), .seg_leds(leds_a), .seg_ncs(ncs_a),
      .num(num_a), .num_valid(vld_a), .frame_err(err_a), .digit_mask(mask_a));

   seg_scan_capture #(.STABLE_CYC(3), .TIMEOUT_CYC(64)) u_b (
      .clk(clk), .rst_n(rst_n), .seg_leds(leds_b), .seg_ncs(ncs_b),
      .num(num_b), .num_valid(vld_b), .frame_err(err_b), .digit_mask(mask_b));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic [23:0] q_a[$], q_b[$];
   int vcnt_a = 0, ecnt_a = 0, vcnt_b = 0, ecnt_b = 0;
   int cyc = 0, last_acc_cyc = 0, last_err_cyc = 0;
   logic [5:0] prev_mask_a = 6'h00;

   typedef struct {
      logic [23:0] val;
      bit          rev;
      bit          dpr;
      logic [23:0] exp_num;
   } frame_t;
   frame_t tbl[3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [3:0] n);
      case (n)
         4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
         4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
         4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h05;  4'hB: return 8'hC1;
         4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
      endcase
   endfunction

   function automatic logic [5:0] sel(input int d);
      logic [5:0] m;
      m = 6'b100000 >> d;
      return ~m;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (vld_a) begin
            vcnt_a++;
            if (q_a.size() == 0) begin
               checks++; failures++;
               $display("FAIL num_valid_a: got pulse with num=%h, expected none", num_a);
            end else chk("num_a", 32'(num_a), 32'(q_a.pop_front()));
         end
         if (err_a) begin ecnt_a++; last_err_cyc = cyc; end
         if (mask_a != prev_mask_a && mask_a != 6'h00) last_acc_cyc = cyc;
         prev_mask_a = mask_a;
         if (vld_b) begin
            vcnt_b++;
            if (q_b.size() == 0) begin
               checks++; failures++;
               $display("FAIL num_valid_b: got pulse with num=%h, expected none", num_b);
            end else chk("num_b", 32'(num_b), 32'(q_b.pop_front()));
         end
         if (err_b) ecnt_b++;
      end
   end

   task automatic step_a(input logic [5:0] ncs, input logic [7:0] leds);
      @(negedge clk);
      ncs_a = ncs; leds_a = leds;
   endtask

   task automatic step_b(input logic [5:0] ncs, input logic [7:0] leds);
      @(negedge clk);
      ncs_b = ncs; leds_b = leds;
   endtask

   task automatic idle_a(input int n);
      repeat (n) step_a(6'h3F, 8'hFF);
   endtask

   task automatic hold_b(input logic [5:0] ncs, input logic [7:0] leds, input int n);
      repeat (n) step_b(ncs, leds);
   endtask

   task automatic frame_a(input logic [23:0] val, input bit rev, input bit dpr);
      for (int k = 0; k < 6; k++) begin
         int d;
         logic [7:0] s;
         d = rev ? 5 - k : k;
         s = enc(val[d*4 +: 4]);
         if (dpr) s[0] = 1'($urandom_range(0, 1));
         step_a(sel(d), s);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int e0, v0;
      logic [23:0] n0;

      tbl[0] = '{24'h12AB5F, 1'b0, 1'b0, 24'h12AB5F};
      tbl[1] = '{24'h12AB5F, 1'b0, 1'b0, 24'h12AB5F};
      tbl[2] = '{24'hFEDCBA, 1'b1, 1'b1, 24'hFEDCBA};

      repeat (2) @(negedge clk);
      chk("reset num", 32'(num_a), 32'h0);
      chk("reset num_valid", 32'(vld_a), 32'h0);
      chk("reset frame_err", 32'(err_a), 32'h0);
      chk("reset digit_mask", 32'(mask_a), 32'h0);
      rst_n = 1'b1;
      idle_a(2);

      // Frame table, back-to-back scans
      for (int i = 0; i < 3; i++) begin
         frame_a(tbl[i].val, tbl[i].rev, tbl[i].dpr);
         q_a.push_back(tbl[i].exp_num);
      end
      idle_a(4);
      chk("table pulses", 32'(vcnt_a), 32'd3);
      chk("table queue drained", 32'(q_a.size()), 32'd0);
      chk("table mask cleared", 32'(mask_a), 32'h0);
      chk("table no err", 32'(ecnt_a), 32'd0);

      // Bad pattern on digit3 mid-frame
      e0 = ecnt_a;
      step_a(sel(0), enc(4'h8));
      step_a(sel(1), enc(4'h7));
      step_a(sel(2), enc(4'h6));
      step_a(sel(3), 8'hFF);
      idle_a(3);
      chk("pattern err pulse", 32'(ecnt_a - e0), 32'd1);
      chk("pattern err mask", 32'(mask_a), 32'h0);
      chk("pattern err num kept", 32'(num_a), 32'hFEDCBA);
      frame_a(24'h9ABCDE, 1'b0, 1'b0);
      q_a.push_back(24'h9ABCDE);
      idle_a(4);
      chk("after err queue drained", 32'(q_a.size()), 32'd0);
      chk("after err num", 32'(num_a), 32'h9ABCDE);

      // Multi-select error held stable: exactly one pulse
      e0 = ecnt_a;
      repeat (3) step_a(6'b001111, 8'h03);
      idle_a(3);
      chk("select err pulse", 32'(ecnt_a - e0), 32'd1);
      chk("select err mask", 32'(mask_a), 32'h0);

      // Long blanking changes nothing
      e0 = ecnt_a; v0 = vcnt_a; n0 = num_a;
      idle_a(20);
      chk("blank err", 32'(ecnt_a - e0), 32'd0);
      chk("blank valid", 32'(vcnt_a - v0), 32'd0);
      chk("blank num", 32'(num_a), 32'(n0));
      chk("blank mask", 32'(mask_a), 32'h0);

      // Partial frame times out 64 cycles after the last accept
      e0 = ecnt_a;
      step_a(sel(0), enc(4'h1));
      step_a(sel(1), enc(4'h2));
      step_a(sel(2), enc(4'h3));
      for (int k = 0; k < 120 && ecnt_a == e0; k++) idle_a(1);
      chk("timeout err pulse", 32'(ecnt_a - e0), 32'd1);
      chk("timeout latency", 32'(last_err_cyc - last_acc_cyc), 32'd64);
      chk("timeout mask", 32'(mask_a), 32'h0);
      chk("timeout num kept", 32'(num_a), 32'h9ABCDE);

      // Stability filter: a 2-cycle glitch on digit2 must not be captured
      hold_b(sel(0), enc(4'h5), 3);
      hold_b(sel(1), enc(4'h6), 3);
      hold_b(sel(2), 8'h99, 2);
      hold_b(sel(2), 8'h9F, 3);
      hold_b(sel(3), enc(4'h7), 3);
      hold_b(sel(4), enc(4'hA), 3);
      hold_b(sel(5), enc(4'hC), 3);
      q_b.push_back(24'hCA7165);
      hold_b(6'h3F, 8'hFF, 6);
      chk("stable queue drained", 32'(q_b.size()), 32'd0);
      chk("stable num", 32'(num_b), 32'hCA7165);
      chk("stable pulses", 32'(vcnt_b), 32'd1);
      chk("stable no err", 32'(ecnt_b), 32'd0);

      // Asynchronous reset in the middle of a frame
      step_a(sel(0), enc(4'h1));
      step_a(sel(1), enc(4'h2));
      step_a(sel(2), enc(4'h3));
      idle_a(2);
      chk("midframe mask", 32'(mask_a), 32'h07);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst num", 32'(num_a), 32'h0);
      chk("async rst mask", 32'(mask_a), 32'h0);
      chk("async rst valid", 32'(vld_a), 32'h0);
      chk("async rst err", 32'(err_a), 32'h0);
      chk("async rst num_b", 32'(num_b), 32'h0);
      idle_a(2);
      rst_n = 1'b1;
      idle_a(2);
      frame_a(24'h0F1E2D, 1'b0, 1'b0);
      q_a.push_back(24'h0F1E2D);
      idle_a(4);
      chk("post reset queue drained", 32'(q_a.size()), 32'd0);
      chk("post reset num", 32'(num_a), 32'h0F1E2D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
